// File: rtl/sorter_pkg.sv
// Shared sorter definitions: modulation codes and the per-job word count.
// Used by both the sorter control unit and the sorted-output streamer.
package sorter_pkg;

    localparam logic [1:0] M_QPSK   = 2'd0;
    localparam logic [1:0] M_QAM16  = 2'd1;
    localparam logic [1:0] M_QAM64  = 2'd2;
    localparam logic [1:0] M_QAM256 = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } streamState_t;

    // Constellation size 4^(m+1), clamped to what the sorter can hold.
    function automatic int job_len(input logic [1:0] m, input int numOutputs);
        int n;
        n = 4 << (2 * int'(m));
        return (n > numOutputs) ? numOutputs : n;
    endfunction

endpackage

// File: rtl/sorted_stream_out.sv
// Captures the sorter's vector on done_in and streams it smallest-first; word 0 one cycle
// after done_in, one word per cycle under out_ready, outputs frozen while stalled.
module sorted_stream_out
    import sorter_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int NUM_OUTPUTS = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            done_in,
    input  logic [1:0]                      M_in,
    input  logic [NUM_OUTPUTS*WIDTH-1:0]    y_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [$clog2(NUM_OUTPUTS)-1:0]  out_idx,
    output logic                            out_last,
    output logic                            busy,
    output logic                            overrun
);

    localparam int IDXW = $clog2(NUM_OUTPUTS);

    streamState_t                   state;
    streamState_t                   stateNext;
    logic [NUM_OUTPUTS*WIDTH-1:0]   buffer;
    logic [IDXW:0]                  idx;
    logic [IDXW:0]                  lastIdx;
    logic [IDXW-1:0]                wordIdx;
    logic                           xfer;
    logic                           finalXfer;
    logic                           loadJob;
    logic                           advance;
    logic                           setOverrun;

    // Every output is a function of registers only, so valid never follows ready.
    assign out_valid = (state == SEND);
    assign busy      = out_valid;
    assign wordIdx   = idx[IDXW-1:0];
    assign out_idx   = wordIdx;
    assign out_data  = buffer[wordIdx*WIDTH +: WIDTH];
    assign out_last  = out_valid && (idx == lastIdx);

    assign xfer      = out_valid && out_ready;
    assign finalXfer = xfer && out_last;

    always_comb begin
        stateNext  = state;
        loadJob    = 1'b0;
        advance    = 1'b0;
        setOverrun = 1'b0;
        case (state)
            IDLE: begin
                if (done_in) begin
                    loadJob   = 1'b1;
                    stateNext = SEND;
                end
            end
            SEND: begin
                if (finalXfer) begin
                    // A new job arriving on the last handshake chains with no bubble.
                    if (done_in) begin
                        loadJob = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    advance    = xfer;
                    setOverrun = done_in;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            buffer  <= '0;
            idx     <= '0;
            lastIdx <= '0;
            overrun <= 1'b0;
        end else begin
            state <= stateNext;
            if (loadJob) begin
                buffer  <= y_in;
                idx     <= '0;
                lastIdx <= (IDXW+1)'(job_len(M_in, NUM_OUTPUTS) - 1);
            end else if (advance) begin
                idx <= idx + 1'b1;
            end
            if (setOverrun) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sorted_stream_out.sv
// Directed and random stimulus for sorted_stream_out against a queue-based reference.
module tb_sorted_stream_out;

    localparam int W  = 16;
    localparam int NO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            done_in;
    logic [1:0]      M_in;
    logic [NO*W-1:0] y_in;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [3:0]      out_idx;
    logic            out_last;
    logic            busy;
    logic            overrun;

    always #5 clk = ~clk;

    sorted_stream_out #(.WIDTH(W), .NUM_OUTPUTS(NO)) dut (
        .clk       (clk),
        .rst       (rst),
        .done_in   (done_in),
        .M_in      (M_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    typedef struct {
        logic [W-1:0] data;
        int           idx;
        bit           last;
    } expWord_t;

    expWord_t expQ[$];
    bit       mBusy;
    bit       mOvr;
    int       total = 0;
    int       bad   = 0;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the reference, then check after the edge.
    task automatic step(input logic d, input logic [1:0] m, input logic [NO*W-1:0] y,
                        input logic r, input logic rs);
        int n;
        bit xferNow;
        bit finalNow;
        expWord_t w;
        done_in   = d;
        M_in      = m;
        y_in      = y;
        out_ready = r;
        rst       = rs;
        if (rs) begin
            expQ.delete();
            mBusy = 0;
            mOvr  = 0;
        end else begin
            xferNow  = mBusy && r;
            finalNow = xferNow && (expQ.size() == 1);
            if (xferNow) void'(expQ.pop_front());
            if (finalNow) mBusy = 0;
            if (d) begin
                if (!mBusy) begin
                    n = 4;
                    repeat (int'(m)) n = n * 4;
                    if (n > NO) n = NO;
                    for (int k = 0; k < n; k++) begin
                        w.data = y[k*W +: W];
                        w.idx  = k;
                        w.last = (k == n - 1);
                        expQ.push_back(w);
                    end
                    mBusy = 1;
                end else begin
                    mOvr = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        checkEq("valid", 32'(out_valid), 32'(mBusy));
        checkEq("busy", 32'(busy), 32'(mBusy));
        checkEq("overrun", 32'(overrun), 32'(mOvr));
        if (mBusy && expQ.size() > 0) begin
            checkEq("data", 32'(out_data), 32'(expQ[0].data));
            checkEq("idx", 32'(out_idx), 32'(expQ[0].idx));
            checkEq("last", 32'(out_last), 32'(expQ[0].last));
        end
        if (rs) begin
            checkEq("rst_data", 32'(out_data), 32'h0);
            checkEq("rst_idx", 32'(out_idx), 32'h0);
            checkEq("rst_last", 32'(out_last), 32'h0);
        end
    endtask

    logic [NO*W-1:0] yRamp;
    logic [NO*W-1:0] yAlt;
    logic [NO*W-1:0] yRnd;
    logic [3:0]      stallPat;

    initial begin
        done_in   = 1'b0;
        M_in      = 2'd0;
        y_in      = '0;
        out_ready = 1'b0;
        rst       = 1'b1;
        mBusy     = 0;
        mOvr      = 0;
        for (int k = 0; k < NO; k++) begin
            yRamp[k*W +: W] = 16'h0010 + 16'(k);
            yAlt[k*W +: W]  = 16'hA000 + 16'(k * 3);
        end

        // Reset held, then released.
        repeat (3) step(1'b0, 2'd0, '0, 1'b1, 1'b1);
        step(1'b0, 2'd0, '0, 1'b1, 1'b0);

        // QAM16: full 16-word job at full rate, then idle.
        step(1'b1, 2'd1, yRamp, 1'b1, 1'b0);
        repeat (17) step(1'b0, 2'd1, '0, 1'b1, 1'b0);

        // QPSK: 4 words only.
        step(1'b1, 2'd0, yAlt, 1'b1, 1'b0);
        repeat (5) step(1'b0, 2'd0, '0, 1'b1, 1'b0);

        // Stall pattern 1,0,0,1 on a QAM16 job; M_in wiggles after capture.
        stallPat = 4'b1001;
        step(1'b1, 2'd1, yRamp, 1'b0, 1'b0);
        for (int i = 0; i < 34; i++) step(1'b0, 2'(i), '0, stallPat[i%4], 1'b0);

        // Overrun: done_in at idx 5 of a QAM256 (clamped) job.
        step(1'b1, 2'd3, yAlt, 1'b1, 1'b0);
        repeat (5) step(1'b0, 2'd0, '0, 1'b1, 1'b0);
        step(1'b1, 2'd0, yRamp, 1'b1, 1'b0);
        repeat (12) step(1'b0, 2'd0, '0, 1'b1, 1'b0);

        // Back-to-back on the final transfer, then reset mid-job.
        step(1'b1, 2'd0, yRamp, 1'b1, 1'b0);
        repeat (3) step(1'b0, 2'd0, '0, 1'b1, 1'b0);
        step(1'b1, 2'd1, yAlt, 1'b1, 1'b0);
        repeat (4) step(1'b0, 2'd0, '0, 1'b1, 1'b0);
        step(1'b0, 2'd0, '0, 1'b1, 1'b1);
        step(1'b0, 2'd0, '0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < NO; k++) yRnd[k*W +: W] = 16'($urandom);
            step(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), yRnd,
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
